// File: rtl/br_redirect.sv
// Branch resolution: checks each execute-stage result against the fetch
// prediction, emits register writeback, and drives the fetch redirect handshake.
module br_redirect #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             res_valid,
  output logic             res_ready,
  input  logic [XLEN-1:0]  res_pc,
  input  logic [XLEN-1:0]  res_pred_next,
  input  logic             res_br_valid,
  input  logic [XLEN-1:0]  res_br_target,
  input  logic             res_wr_en,
  input  logic [4:0]       res_rd_idx,
  input  logic [XLEN-1:0]  res_rd_val,
  input  logic             flush_in,
  output logic             wb_valid,
  output logic [4:0]       wb_idx,
  output logic [XLEN-1:0]  wb_val,
  output logic             redir_valid,
  output logic [XLEN-1:0]  redir_pc,
  input  logic             redir_ready,
  output logic             flush_out,
  output logic [CNT_W-1:0] mispred_cnt
);

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    WAIT_ACK = 1'b1
  } state_t;

  state_t          state;
  logic [XLEN-1:0] actual_next;
  logic            accept;
  logic            mispred;
  logic            wb_take;

  // res_ready is gated by rst so nothing is accepted during the reset cycle.
  always_comb begin
    actual_next = res_br_valid ? res_br_target : (res_pc + XLEN'(4));
    res_ready   = (state == IDLE) && !flush_in && rst;
    accept      = res_valid && res_ready;
    mispred     = accept && (actual_next != res_pred_next);
    wb_take     = accept && res_wr_en && (res_rd_idx != 5'd0);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      wb_valid    <= 1'b0;
      wb_idx      <= '0;
      wb_val      <= '0;
      redir_valid <= 1'b0;
      redir_pc    <= '0;
      flush_out   <= 1'b0;
      mispred_cnt <= '0;
    end else begin
      wb_valid  <= wb_take;
      flush_out <= mispred;
      if (wb_take) begin
        wb_idx <= res_rd_idx;
        wb_val <= res_rd_val;
      end
      case (state)
        IDLE: begin
          if (mispred) begin
            state       <= WAIT_ACK;
            redir_valid <= 1'b1;
            redir_pc    <= actual_next;
            if (mispred_cnt != '1)
              mispred_cnt <= mispred_cnt + CNT_W'(1);
          end
        end
        WAIT_ACK: begin
          // Either a handshake or an external flush retires the pending redirect.
          if (redir_ready || flush_in) begin
            state       <= IDLE;
            redir_valid <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          redir_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_br_redirect.sv
// Self-checking bench for br_redirect: table-driven vectors through a
// scoreboard queue, plus hand-written multi-cycle corner-case sequences.
module tb_br_redirect;

  logic        clk = 1'b0;
  logic        rst;
  logic        res_valid;
  logic [31:0] res_pc, res_pred_next, res_br_target, res_rd_val;
  logic        res_br_valid, res_wr_en;
  logic [4:0]  res_rd_idx;
  logic        flush_in, redir_ready;

  logic        res_ready, wb_valid, redir_valid, flush_out;
  logic [4:0]  wb_idx;
  logic [31:0] wb_val, redir_pc, mispred_cnt;

  logic        s_res_ready, s_wb_valid, s_redir_valid, s_flush_out;
  logic [4:0]  s_wb_idx;
  logic [31:0] s_wb_val, s_redir_pc;
  logic [1:0]  s_cnt;

  always #5 clk = ~clk;

  br_redirect #(.XLEN(32), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .res_valid(res_valid), .res_ready(res_ready),
    .res_pc(res_pc), .res_pred_next(res_pred_next), .res_br_valid(res_br_valid),
    .res_br_target(res_br_target), .res_wr_en(res_wr_en), .res_rd_idx(res_rd_idx),
    .res_rd_val(res_rd_val), .flush_in(flush_in), .wb_valid(wb_valid),
    .wb_idx(wb_idx), .wb_val(wb_val), .redir_valid(redir_valid),
    .redir_pc(redir_pc), .redir_ready(redir_ready), .flush_out(flush_out),
    .mispred_cnt(mispred_cnt)
  );

  // Narrow counter instance to reach saturation with a handful of mispredicts.
  br_redirect #(.XLEN(32), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .res_valid(res_valid), .res_ready(s_res_ready),
    .res_pc(res_pc), .res_pred_next(res_pred_next), .res_br_valid(res_br_valid),
    .res_br_target(res_br_target), .res_wr_en(res_wr_en), .res_rd_idx(res_rd_idx),
    .res_rd_val(res_rd_val), .flush_in(flush_in), .wb_valid(s_wb_valid),
    .wb_idx(s_wb_idx), .wb_val(s_wb_val), .redir_valid(s_redir_valid),
    .redir_pc(s_redir_pc), .redir_ready(redir_ready), .flush_out(s_flush_out),
    .mispred_cnt(s_cnt)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] pred;
    logic        br;
    logic [31:0] tgt;
    logic        wr;
    logic [4:0]  rd;
    logic [31:0] val;
    logic        e_wb;
    logic        e_redir;
    logic [31:0] e_pc;
  } vec_t;

  typedef struct {
    logic        wb;
    logic [4:0]  idx;
    logic [31:0] val;
    logic        redir;
    logic [31:0] rpc;
    int unsigned cnt;
  } exp_t;

  vec_t        vecs[8];
  exp_t        exp_q[$];
  int unsigned model_cnt = 0;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input vec_t v);
    res_valid     = 1'b1;
    res_pc        = v.pc;
    res_pred_next = v.pred;
    res_br_valid  = v.br;
    res_br_target = v.tgt;
    res_wr_en     = v.wr;
    res_rd_idx    = v.rd;
    res_rd_val    = v.val;
  endtask

  function automatic int unsigned sat3(input int unsigned c);
    return (c > 3) ? 3 : c;
  endfunction

  task automatic check_out(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 64'd1, 64'd0);
      return;
    end
    e = exp_q.pop_front();
    chk({tag, "_wb_valid"}, wb_valid, e.wb);
    if (e.wb) begin
      chk({tag, "_wb_idx"}, wb_idx, e.idx);
      chk({tag, "_wb_val"}, wb_val, e.val);
    end
    chk({tag, "_redir_valid"}, redir_valid, e.redir);
    chk({tag, "_flush_out"}, flush_out, e.redir);
    if (e.redir) chk({tag, "_redir_pc"}, redir_pc, e.rpc);
    chk({tag, "_cnt"}, mispred_cnt, e.cnt);
    chk({tag, "_sat_cnt"}, s_cnt, sat3(e.cnt));
  endtask

  initial begin
    vec_t v;
    exp_t e;

    vecs[0] = '{32'h100, 32'h104, 1'b0, 32'h0, 1'b1, 5'd5, 32'hAB, 1'b1, 1'b0, 32'h0};
    vecs[1] = '{32'h100, 32'h104, 1'b1, 32'h200, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 32'h200};
    vecs[2] = '{32'hFFFFFFFC, 32'h0, 1'b0, 32'h0, 1'b1, 5'd0, 32'h55, 1'b0, 1'b0, 32'h0};
    vecs[3] = '{32'hFFFFFFFC, 32'h100, 1'b0, 32'h0, 1'b0, 5'd3, 32'h0, 1'b0, 1'b1, 32'h0};
    vecs[4] = '{32'h300, 32'h400, 1'b1, 32'h400, 1'b1, 5'd31, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0};
    vecs[5] = '{32'h40, 32'h44, 1'b1, 32'h44, 1'b0, 5'd2, 32'h0, 1'b0, 1'b0, 32'h0};
    vecs[6] = '{32'h40, 32'h80, 1'b0, 32'h999, 1'b1, 5'd1, 32'h1, 1'b1, 1'b1, 32'h44};
    vecs[7] = '{32'h500, 32'h504, 1'b0, 32'h0, 1'b0, 5'd7, 32'h77, 1'b0, 1'b0, 32'h0};

    rst = 1'b0; res_valid = 1'b0; res_pc = '0; res_pred_next = '0; res_br_valid = 1'b0;
    res_br_target = '0; res_wr_en = 1'b0; res_rd_idx = '0; res_rd_val = '0;
    flush_in = 1'b0; redir_ready = 1'b0;

    // Reset state
    step();
    step();
    chk("rst_ready", res_ready, 1'b0);
    chk("rst_wb_valid", wb_valid, 1'b0);
    chk("rst_redir_valid", redir_valid, 1'b0);
    chk("rst_flush_out", flush_out, 1'b0);
    chk("rst_cnt", mispred_cnt, 32'd0);

    // Table vectors; first one is offered in the very first cycle out of reset
    rst = 1'b1;
    redir_ready = 1'b1;
    foreach (vecs[i]) begin
      v = vecs[i];
      drive(v);
      #1;
      chk($sformatf("v%0d_ready", i), res_ready, 1'b1);
      if (v.e_redir) model_cnt++;
      e = '{v.e_wb, v.rd, v.val, v.e_redir, v.e_pc, model_cnt};
      exp_q.push_back(e);
      step();
      res_valid = 1'b0;
      check_out($sformatf("v%0d", i));
      if (v.e_redir) begin
        chk($sformatf("v%0d_wait_ready", i), res_ready, 1'b0);
        step();
        chk($sformatf("v%0d_ack_redir", i), redir_valid, 1'b0);
        chk($sformatf("v%0d_ack_flush", i), flush_out, 1'b0);
        chk($sformatf("v%0d_ack_idle", i), res_ready, 1'b1);
      end
    end
    step();
    chk("wb_one_cycle", wb_valid, 1'b0);

    // Redirect held for three cycles with redir_ready low
    redir_ready = 1'b0;
    v = '{32'h100, 32'h104, 1'b1, 32'h200, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 32'h200};
    drive(v);
    step();
    model_cnt++;
    v = '{32'h600, 32'h0, 1'b0, 32'h0, 1'b1, 5'd9, 32'h1234, 1'b0, 1'b0, 32'h0};
    drive(v);
    for (int unsigned c = 0; c < 3; c++) begin
      chk($sformatf("hold%0d_redir_valid", c), redir_valid, 1'b1);
      chk($sformatf("hold%0d_redir_pc", c), redir_pc, 32'h200);
      chk($sformatf("hold%0d_ready", c), res_ready, 1'b0);
      chk($sformatf("hold%0d_flush", c), flush_out, (c == 0) ? 1'b1 : 1'b0);
      chk($sformatf("hold%0d_cnt", c), mispred_cnt, model_cnt);
      if (c != 0) chk($sformatf("hold%0d_wb", c), wb_valid, 1'b0);
      if (c != 2) step();
    end
    res_valid = 1'b0;
    redir_ready = 1'b1;
    step();
    chk("hold_done_redir", redir_valid, 1'b0);
    chk("hold_done_idle", res_ready, 1'b1);

    // flush_in in IDLE blocks acceptance
    v = '{32'h700, 32'h0, 1'b0, 32'h0, 1'b1, 5'd4, 32'h44, 1'b0, 1'b0, 32'h0};
    drive(v);
    flush_in = 1'b1;
    #1;
    chk("idle_flush_ready", res_ready, 1'b0);
    step();
    res_valid = 1'b0;
    flush_in = 1'b0;
    chk("idle_flush_wb", wb_valid, 1'b0);
    chk("idle_flush_redir", redir_valid, 1'b0);
    chk("idle_flush_flush_out", flush_out, 1'b0);
    chk("idle_flush_cnt", mispred_cnt, model_cnt);

    // flush_in in WAIT_ACK cancels the redirect
    redir_ready = 1'b0;
    v = '{32'h800, 32'h0, 1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 32'h804};
    drive(v);
    step();
    model_cnt++;
    res_valid = 1'b0;
    chk("wflush_pre_redir", redir_valid, 1'b1);
    chk("wflush_pre_pc", redir_pc, 32'h804);
    flush_in = 1'b1;
    step();
    chk("wflush_redir", redir_valid, 1'b0);
    chk("wflush_flush_out", flush_out, 1'b0);
    chk("wflush_cnt", mispred_cnt, model_cnt);
    chk("wflush_sat_cnt", s_cnt, sat3(model_cnt));
    flush_in = 1'b0;
    #1;
    chk("wflush_idle", res_ready, 1'b1);

    // Reset coinciding with a redirect handshake
    v = '{32'h900, 32'h0, 1'b1, 32'hA00, 1'b1, 5'd6, 32'h66, 1'b1, 1'b1, 32'hA00};
    drive(v);
    step();
    res_valid = 1'b0;
    chk("rsths_pre_redir", redir_valid, 1'b1);
    chk("rsths_pre_wb", wb_valid, 1'b1);
    redir_ready = 1'b1;
    rst = 1'b0;
    #1;
    chk("rsths_ready", res_ready, 1'b0);
    step();
    model_cnt = 0;
    chk("rsths_redir_valid", redir_valid, 1'b0);
    chk("rsths_redir_pc", redir_pc, 32'h0);
    chk("rsths_wb_valid", wb_valid, 1'b0);
    chk("rsths_wb_idx", wb_idx, 5'd0);
    chk("rsths_wb_val", wb_val, 32'h0);
    chk("rsths_flush_out", flush_out, 1'b0);
    chk("rsths_cnt", mispred_cnt, 32'd0);
    chk("rsths_sat_cnt", s_cnt, 2'd0);
    rst = 1'b1;
    #1;
    chk("rsths_after_ready", res_ready, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/br_redirect.md
BR_REDIRECT -- requirements
Module: br_redirect

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, giving the width of PC, target and register data.
REQ-002 The block SHALL have parameter CNT_W, default 32, giving the width of the mispredict counter.
REQ-003 Port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1: synchronous, active-low reset, sampled on clk.
REQ-005 Port res_valid, input, 1: an execute-stage result is offered.
REQ-006 Port res_ready, output, 1: the block accepts the offered result this cycle.
REQ-007 Port res_pc, input, XLEN: PC of the resolved instruction.
REQ-008 Port res_pred_next, input, XLEN: next PC that fetch predicted for this instruction.
REQ-009 Port res_br_valid, input, 1: control transfer taken.
REQ-010 Port res_br_target, input, XLEN: taken target.
REQ-011 Port res_wr_en, input, 1: instruction writes rd.
REQ-012 Port res_rd_idx, input, 5: destination register.
REQ-013 Port res_rd_val, input, XLEN: destination value.
REQ-014 Port flush_in, input, 1: external flush (exception/trap path).
REQ-015 Port wb_valid, output, 1: register writeback strobe.
REQ-016 Port wb_idx, output, 5: writeback register index.
REQ-017 Port wb_val, output, XLEN: writeback data.
REQ-018 Port redir_valid, output, 1: fetch redirect request.
REQ-019 Port redir_pc, output, XLEN: redirect address.
REQ-020 Port redir_ready, input, 1: fetch accepts the redirect.
REQ-021 Port flush_out, output, 1: one-cycle squash pulse to younger stages.
REQ-022 Port mispred_cnt, output, CNT_W: count of issued redirects.

Function
REQ-023 The block SHALL compute actual_next = res_br_valid ? res_br_target : res_pc + 4, modulo 2^XLEN (the addition wraps).
REQ-024 The block SHALL be an FSM with states IDLE and WAIT_ACK.
REQ-025 In IDLE the block SHALL drive res_ready = !flush_in; in WAIT_ACK it SHALL drive res_ready = 0.
REQ-026 An accepted result SHALL be res_valid && res_ready.
REQ-027 An accepted result with res_wr_en = 1 and res_rd_idx != 0 SHALL produce wb_valid = 1 for exactly the next cycle, with wb_idx and wb_val registered from the input; otherwise wb_valid = 0.
REQ-028 A mispredict SHALL be an accepted result with actual_next != res_pred_next.
REQ-029 On a mispredict the block SHALL, from the next cycle: enter WAIT_ACK, drive redir_valid = 1 with redir_pc = actual_next, pulse flush_out = 1 for exactly one cycle, and increment mispred_cnt by 1.
REQ-030 mispred_cnt SHALL saturate at all-ones and never wrap.
REQ-031 redir_pc SHALL hold stable while redir_valid = 1 and redir_ready = 0.
REQ-032 A cycle with redir_valid && redir_ready SHALL complete the handshake: next cycle redir_valid = 0 and state = IDLE.
REQ-033 A handshake in the first redir_valid cycle SHALL be legal, giving a one-cycle WAIT_ACK.
REQ-034 flush_in = 1 in WAIT_ACK SHALL cancel the pending redirect: next cycle redir_valid = 0, state = IDLE; mispred_cnt is not decremented.
REQ-035 flush_in = 1 in IDLE SHALL block acceptance, so no writeback, redirect or count change results that cycle.
REQ-036 flush_in SHALL NOT itself assert flush_out.
REQ-037 A correctly predicted taken branch SHALL cause no redirect and no flush_out.
REQ-038 End-to-end latency from acceptance to wb_valid, redir_valid or flush_out SHALL be exactly 1 cycle.

Reset
REQ-039 While rst = 0 at a rising edge, the block SHALL set: state = IDLE, wb_valid = 0, wb_idx = 0, wb_val = 0, redir_valid = 0, redir_pc = 0, flush_out = 0, mispred_cnt = 0.
REQ-040 Reset SHALL take priority over every concurrent event, including a pending redirect or a handshake in the same cycle.
REQ-041 res_ready SHALL be 0 during the reset cycle, and the first acceptance can occur in the first cycle with rst = 1.

Verification
REQ-042 Scenario: pc = 0x100, pred = 0x104, br_valid = 0, wr_en = 1, rd = 5, val = 0xAB. Required next cycle: wb_valid = 1, wb_idx = 5, wb_val = 0xAB; no redirect.
REQ-043 Scenario: pc = 0x100, pred = 0x104, br_valid = 1, target = 0x200, redir_ready held 0 for 3 cycles. Required: flush_out high for 1 cycle; redir_valid = 1 with pc 0x200 stable for 3 cycles; res_ready = 0 throughout; mispred_cnt = 1; IDLE one cycle after redir_ready.
REQ-044 Scenario: pc = 0xFFFFFFFC, br_valid = 0, pred = 0x0. Required: no mispredict, due to wrap. Same stimulus with pred = 0x100 -> redir_pc = 0x0.
REQ-045 Scenario: flush_in asserted during WAIT_ACK. Required next cycle: redir_valid = 0, state IDLE, mispred_cnt unchanged.
REQ-046 Scenario: preload mispred_cnt at all-ones, then a mispredict. Required: count stays all-ones.
REQ-047 Scenario: rst = 0 in the same cycle as redir_valid && redir_ready. Required next cycle: all outputs at reset values.
